// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and helpers for the register-bank write-port arbiter.
// Pulled in by the interface, the hold timer and the arbiter itself.
package reg_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_PROG = 2'd1,
        OWN_RTC  = 2'd2,
        TURN     = 2'd3
    } arb_state_e;

    // Owner codes double as the bank mux select value.
    localparam logic OWNER_RTC  = 1'b0;
    localparam logic OWNER_PROG = 1'b1;

    localparam int HOLD_CNT_W = 8;

    // Winner of IDLE arbitration; only meaningful when at least one side requests.
    function automatic logic pick_owner(input logic req_prog, input logic req_rtc,
                                        input logic last_owner);
        logic owner;
        if (req_prog && req_rtc) begin
            owner = ~last_owner;
        end else if (req_prog) begin
            owner = OWNER_PROG;
        end else begin
            owner = OWNER_RTC;
        end
        return owner;
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side and bank-side signals of the arbiter, bundled as one interface.
// The arbiter uses the slave view; requesters and the bank use the master view.
interface reg_bank_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          req_prog;
    logic          we_prog;
    logic [AW-1:0] addr_prog;
    logic [DW-1:0] data_prog;
    logic          req_rtc;
    logic          we_rtc;
    logic [AW-1:0] addr_rtc;
    logic [DW-1:0] data_rtc;
    logic          gnt_prog;
    logic          gnt_rtc;
    logic          sel;
    logic          bank_we;
    logic [AW-1:0] bank_addr;
    logic [DW-1:0] bank_data;
    logic          busy;

    modport master (
        output req_prog, we_prog, addr_prog, data_prog,
        output req_rtc, we_rtc, addr_rtc, data_rtc,
        input  gnt_prog, gnt_rtc, sel, bank_we, bank_addr, bank_data, busy
    );

    modport slave (
        input  req_prog, we_prog, addr_prog, data_prog,
        input  req_rtc, we_rtc, addr_rtc, data_rtc,
        output gnt_prog, gnt_rtc, sel, bank_we, bank_addr, bank_data, busy
    );

endinterface

// File: rtl/reg_bank_arbiter_hold_timer.sv
// Saturating contention counter; term_o flags that the owner has used its
// last allowed contended cycle (count == HOLD_MAX-1).
module reg_bank_arbiter_hold_timer
    import reg_bank_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam logic [HOLD_CNT_W-1:0] TERM_CNT = HOLD_CNT_W'(HOLD_MAX - 1);
    localparam logic [HOLD_CNT_W-1:0] SAT_CNT  = {HOLD_CNT_W{1'b1}};

    logic [HOLD_CNT_W-1:0] cnt_q;
    logic [HOLD_CNT_W-1:0] cnt_d;
    logic                  term_q;

    // Next count: clear wins over enable, and the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {HOLD_CNT_W{1'b0}};
        end else if (en_i && (cnt_q != SAT_CNT)) begin
            cnt_d = cnt_q + HOLD_CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with the terminal flag registered alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= {HOLD_CNT_W{1'b0}};
            term_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= (cnt_d == TERM_CNT);
        end
    end

    assign term_o = term_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-requester arbiter for the register bank write port: round-robin grant,
// bounded hold under contention, one dead cycle between owners, registered datapath.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int HOLD_MAX = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_bank_arbiter_if.slave    bus
);

    arb_state_e    state_q;
    logic          gnt_prog_q;
    logic          gnt_rtc_q;
    logic          sel_q;
    logic          bank_we_q;
    logic [AW-1:0] bank_addr_q;
    logic [DW-1:0] bank_data_q;
    logic          busy_q;
    logic          last_owner_q;

    logic          in_own_s;
    logic          mine_req_s;
    logic          other_req_s;
    logic          release_s;
    logic          hold_en_s;
    logic          hold_clr_s;
    logic          hold_term_s;
    logic          next_owner_s;

    // Release decision for the current owner and hold-timer control.
    always_comb begin
        in_own_s    = 1'b0;
        mine_req_s  = 1'b0;
        other_req_s = 1'b0;
        case (state_q)
            OWN_PROG: begin
                in_own_s    = 1'b1;
                mine_req_s  = bus.req_prog;
                other_req_s = bus.req_rtc;
            end
            OWN_RTC: begin
                in_own_s    = 1'b1;
                mine_req_s  = bus.req_rtc;
                other_req_s = bus.req_prog;
            end
            IDLE, TURN: begin
                in_own_s    = 1'b0;
                mine_req_s  = 1'b0;
                other_req_s = 1'b0;
            end
            default: begin
                in_own_s    = 1'b0;
                mine_req_s  = 1'b0;
                other_req_s = 1'b0;
            end
        endcase
        release_s    = in_own_s && (!mine_req_s || (other_req_s && hold_term_s));
        hold_en_s    = in_own_s && other_req_s && !release_s;
        hold_clr_s   = !hold_en_s;
        next_owner_s = pick_owner(bus.req_prog, bus.req_rtc, last_owner_q);
    end

    reg_bank_arbiter_hold_timer #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_timer (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (hold_clr_s),
        .en_i   (hold_en_s),
        .term_o (hold_term_s)
    );

    // Arbitration FSM with registered grants, select and bank write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            gnt_prog_q   <= 1'b0;
            gnt_rtc_q    <= 1'b0;
            sel_q        <= 1'b0;
            bank_we_q    <= 1'b0;
            bank_addr_q  <= {AW{1'b0}};
            bank_data_q  <= {DW{1'b0}};
            busy_q       <= 1'b0;
            last_owner_q <= OWNER_RTC;
        end else begin
            case (state_q)
                IDLE: begin
                    bank_we_q <= 1'b0;
                    if (bus.req_prog || bus.req_rtc) begin
                        busy_q <= 1'b1;
                        sel_q  <= next_owner_s;
                        if (next_owner_s == OWNER_PROG) begin
                            state_q    <= OWN_PROG;
                            gnt_prog_q <= 1'b1;
                        end else begin
                            state_q   <= OWN_RTC;
                            gnt_rtc_q <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                OWN_PROG: begin
                    if (release_s) begin
                        // A write strobed on the release edge never reaches the bank.
                        state_q      <= TURN;
                        gnt_prog_q   <= 1'b0;
                        bank_we_q    <= 1'b0;
                        last_owner_q <= OWNER_PROG;
                    end else begin
                        bank_we_q   <= bus.we_prog;
                        bank_addr_q <= bus.addr_prog;
                        bank_data_q <= bus.data_prog;
                    end
                end
                OWN_RTC: begin
                    if (release_s) begin
                        state_q      <= TURN;
                        gnt_rtc_q    <= 1'b0;
                        bank_we_q    <= 1'b0;
                        last_owner_q <= OWNER_RTC;
                    end else begin
                        bank_we_q   <= bus.we_rtc;
                        bank_addr_q <= bus.addr_rtc;
                        bank_data_q <= bus.data_rtc;
                    end
                end
                TURN: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    bank_we_q <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    gnt_prog_q <= 1'b0;
                    gnt_rtc_q  <= 1'b0;
                    bank_we_q  <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_prog  = gnt_prog_q;
    assign bus.gnt_rtc   = gnt_rtc_q;
    assign bus.sel       = sel_q;
    assign bus.bank_we   = bank_we_q;
    assign bus.bank_addr = bank_addr_q;
    assign bus.bank_data = bank_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// against a transaction-level model of owner, dead-cycle gap and contention count.
module tb_reg_bank_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int HM = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    reg_bank_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    reg_bank_arbiter #(.AW(AW), .DW(DW), .HOLD_MAX(HM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Model: owner 0=none 1=PROG 2=RTC; gap counts remaining dead cycles.
    int            m_owner, m_gap, m_cont, m_last;
    logic          m_sel, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic model_reset();
        m_owner = 0; m_gap = 0; m_cont = 0; m_last = 2;
        m_sel = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_step(input logic pr, input logic wp, input logic [AW-1:0] ap,
                              input logic [DW-1:0] dp, input logic rr, input logic wr,
                              input logic [AW-1:0] ar, input logic [DW-1:0] dr);
        logic mine, other;
        if (m_owner != 0) begin
            mine  = (m_owner == 1) ? pr : rr;
            other = (m_owner == 1) ? rr : pr;
            if (!mine || (other && m_cont == HM - 1)) begin
                m_last = m_owner; m_owner = 0; m_gap = 1; m_cont = 0; m_we = 1'b0;
            end else begin
                m_cont = other ? ((m_cont < 255) ? m_cont + 1 : 255) : 0;
                m_we   = (m_owner == 1) ? wp : wr;
                m_addr = (m_owner == 1) ? ap : ar;
                m_data = (m_owner == 1) ? dp : dr;
            end
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1; m_we = 1'b0;
        end else begin
            m_we = 1'b0;
            if (pr && rr)  m_owner = (m_last == 1) ? 2 : 1;
            else if (pr)   m_owner = 1;
            else if (rr)   m_owner = 2;
            if (m_owner != 0) m_sel = (m_owner == 1);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("gnt_prog",  bus.gnt_prog,  (m_owner == 1));
        check_val("gnt_rtc",   bus.gnt_rtc,   (m_owner == 2));
        check_val("sel",       bus.sel,       m_sel);
        check_val("busy",      bus.busy,      (m_owner != 0) || (m_gap != 0));
        check_val("bank_we",   bus.bank_we,   m_we);
        check_val("bank_addr", bus.bank_addr, m_addr);
        check_val("bank_data", bus.bank_data, m_data);
    endtask

    task automatic drive(input logic pr, input logic wp, input logic [AW-1:0] ap,
                         input logic [DW-1:0] dp, input logic rr, input logic wr,
                         input logic [AW-1:0] ar, input logic [DW-1:0] dr);
        bus.req_prog = pr; bus.we_prog = wp; bus.addr_prog = ap; bus.data_prog = dp;
        bus.req_rtc  = rr; bus.we_rtc  = wr; bus.addr_rtc  = ar; bus.data_rtc  = dr;
    endtask

    task automatic tick();
        logic pr, wp, rr, wr;
        logic [AW-1:0] ap, ar;
        logic [DW-1:0] dp, dr;
        pr = bus.req_prog; wp = bus.we_prog; ap = bus.addr_prog; dp = bus.data_prog;
        rr = bus.req_rtc;  wr = bus.we_rtc;  ar = bus.addr_rtc;  dr = bus.data_rtc;
        @(posedge clk);
        model_step(pr, wp, ap, dp, rr, wr, ar, dr);
        #1;
        check_all();
    endtask

    // Called just after tick(): asserts reset mid-cycle and checks it acts without a clock edge.
    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        check_val("rst_gnt_rtc", bus.gnt_rtc, 1'b0);
        check_val("rst_bank_we", bus.bank_we, 1'b0);
        #2 reset = 1'b1;
    endtask

    initial begin
        logic pr, rr;
        model_reset();

        // Reset held with random inputs across a clock edge.
        drive(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
              1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
        #12;
        check_all();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        #2 reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // Single PROG write.
        drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        tick();
        check_val("prog_gnt_c1", bus.gnt_prog, 1'b1);
        check_val("prog_sel_c1", bus.sel, 1'b1);
        tick();
        drive(1'b1, 1'b1, 4'h3, 8'h25, 1'b0, 1'b0, 4'h0, 8'h00);
        tick();
        check_val("prog_we_c3",   bus.bank_we, 1'b1);
        check_val("prog_addr_c3", bus.bank_addr, 4'h3);
        check_val("prog_data_c3", bus.bank_data, 8'h25);
        drive(1'b1, 1'b0, 4'h3, 8'h25, 1'b0, 1'b0, 4'h0, 8'h00);
        tick();
        drive(1'b0, 1'b0, 4'h3, 8'h25, 1'b0, 1'b0, 4'h0, 8'h00);
        tick();
        check_val("prog_gnt_c5", bus.gnt_prog, 1'b0);
        for (int i = 0; i < 3; i++) tick();

        // Simultaneous requests after reset, contention forces PROG out after HM cycles.
        async_reset();
        drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00);
        tick();
        check_val("both_gnt_prog_c1", bus.gnt_prog, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        tick();
        check_val("forced_gnt_prog_c5", bus.gnt_prog, 1'b0);
        check_val("forced_busy_c5", bus.busy, 1'b1);
        tick();
        check_val("turn_gnt_rtc_c6", bus.gnt_rtc, 1'b0);
        tick();
        check_val("rr_gnt_rtc_c7", bus.gnt_rtc, 1'b1);
        check_val("rr_sel_c7", bus.sel, 1'b0);
        drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        tick(); tick(); tick();
        check_val("requeue_gnt_prog", bus.gnt_prog, 1'b1);

        // Ungranted RTC write while PROG owns the bank.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'($urandom), 4'h5, DW'($urandom), 1'b0, 1'b1, 4'hA, 8'hEE);
            tick();
            check_val("no_rtc_addr", (bus.bank_addr == 4'hA), 1'b0);
        end
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        for (int i = 0; i < 3; i++) tick();

        // Async reset while RTC is writing, then arbitration restarts from IDLE.
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00);
        tick();
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h7, 8'h5A);
        tick();
        check_val("rtc_we_before_rst", bus.bank_we, 1'b1);
        async_reset();
        tick();
        check_val("rtc_regrant", bus.gnt_rtc, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
        for (int i = 0; i < 3; i++) tick();

        // Randomized traffic with sticky requests and occasional resets.
        pr = 1'b0; rr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            pr = pr ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
            rr = rr ? ($urandom_range(9) != 0) : ($urandom_range(3) == 0);
            drive(pr, 1'($urandom), AW'($urandom), DW'($urandom),
                  rr, 1'($urandom), AW'($urandom), DW'($urandom));
            tick();
            check_val("mutex", bus.gnt_prog && bus.gnt_rtc, 1'b0);
            if ($urandom_range(399) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
